// File: rtl/multi_cycle_cpu.sv
// Multi-cycle CPU: IF/ID/EXE/MEM/WB state machine with req/ack instruction and data ports.
// One instruction is in flight at a time. The register file is read from IR in every state
// and written only in WB, so the store data stays stable while a data access is pending.
module multi_cycle_cpu #(
  parameter int          DATA_W   = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [31:0]       currentAddress,
  output logic [2:0]        state,
  output logic              halted
);
  typedef enum logic [2:0] {
    S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010,
    S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b101
  } cpuState_t;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b010001,
                         OP_OR = 6'b010010, OP_ADDIU = 6'b000010, OP_ORI = 6'b010000,
                         OP_SW = 6'b100110, OP_LW = 6'b100111, OP_BEQ = 6'b110000,
                         OP_BNE = 6'b110001, OP_J = 6'b111000, OP_HALT = 6'b111111;
  localparam int NREGS = 1 << REG_AW;

  cpuState_t         curState;
  logic [31:0]       pc, ir;
  logic [DATA_W-1:0] mdr, aluOut, aluResult;
  logic [DATA_W-1:0] regFile [NREGS];

  logic [5:0]        op;
  logic [REG_AW-1:0] rsIdx, rtIdx, rdIdx, wbIdx;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rsVal, rtVal, sextImm, zextImm, wbData;
  logic [31:0]       pcPlus4, brTarget, jTarget;
  logic              isRType, isIAlu, isMem, isBranch, isKnown, taken;

  assign op      = ir[31:26];
  assign rsIdx   = ir[21 +: REG_AW];
  assign rtIdx   = ir[16 +: REG_AW];
  assign rdIdx   = ir[11 +: REG_AW];
  assign imm     = ir[15:0];
  assign rsVal   = (rsIdx == '0) ? '0 : regFile[rsIdx];
  assign rtVal   = (rtIdx == '0) ? '0 : regFile[rtIdx];
  // Size casts: the signed one sign-extends, both are identity when DATA_W is 16.
  assign sextImm = DATA_W'($signed(imm));
  assign zextImm = DATA_W'(imm);

  assign isRType  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign isIAlu   = (op == OP_ADDIU) || (op == OP_ORI);
  assign isMem    = (op == OP_SW) || (op == OP_LW);
  assign isBranch = (op == OP_BEQ) || (op == OP_BNE);
  assign isKnown  = isRType || isIAlu || isMem || isBranch;
  assign taken    = (op == OP_BEQ) ? (rsVal == rtVal) : (rsVal != rtVal);

  // PC arithmetic is 32-bit and wraps naturally past 32'hFFFF_FFFC.
  assign pcPlus4  = pc + 32'd4;
  assign brTarget = pcPlus4 + {{14{imm[15]}}, imm, 2'b00};
  assign jTarget  = {pcPlus4[31:28], ir[25:0], 2'b00};

  assign wbIdx  = isRType ? rdIdx : rtIdx;
  assign wbData = (op == OP_LW) ? mdr : aluOut;

  // ALU: loads, stores and addiu all use rs + sext(imm)
  always_comb begin
    aluResult = rsVal + sextImm;
    case (op)
      OP_ADD:  aluResult = rsVal + rtVal;
      OP_SUB:  aluResult = rsVal - rtVal;
      OP_AND:  aluResult = rsVal & rtVal;
      OP_OR:   aluResult = rsVal | rtVal;
      OP_ORI:  aluResult = rsVal | zextImm;
      default: aluResult = rsVal + sextImm;
    endcase
  end

  // Requests are gated by Reset so nothing is issued while reset is held.
  assign imem_req       = (curState == S_IF) & Reset;
  assign imem_addr      = pc;
  assign dmem_req       = (curState == S_MEM) & Reset;
  assign dmem_we        = (op == OP_SW);
  assign dmem_addr      = aluOut;
  assign dmem_wdata     = rtVal;
  assign currentAddress = pc;
  assign state          = curState;
  assign halted         = (curState == S_HALT);

  // Main FSM, PC/IR/MDR/ALU-out registers and register-file write port
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc       <= RESET_PC;
      curState <= S_IF;
      ir       <= '0;
      mdr      <= '0;
      aluOut   <= '0;
      for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
    end else begin
      case (curState)
        S_IF: if (imem_ack) begin
          ir       <= imem_rdata;
          curState <= S_ID;
        end
        S_ID: begin
          if (op == OP_J) begin
            pc       <= jTarget;
            curState <= S_IF;
          end else if (op == OP_HALT) begin
            curState <= S_HALT;
          end else if (!isKnown) begin
            pc       <= pcPlus4;
            curState <= S_IF;
          end else begin
            curState <= S_EXE;
          end
        end
        S_EXE: begin
          aluOut <= aluResult;
          if (isBranch) begin
            pc       <= taken ? brTarget : pcPlus4;
            curState <= S_IF;
          end else if (isMem) begin
            curState <= S_MEM;
          end else begin
            curState <= S_WB;
          end
        end
        S_MEM: if (dmem_ack) begin
          if (op == OP_SW) begin
            pc       <= pcPlus4;
            curState <= S_IF;
          end else begin
            mdr      <= dmem_rdata;
            curState <= S_WB;
          end
        end
        S_WB: begin
          if (wbIdx != '0) regFile[wbIdx] <= wbData;
          pc       <= pcPlus4;
          curState <= S_IF;
        end
        S_HALT:  curState <= S_HALT;
        default: curState <= S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: small programs with hand-computed results,
// req/ack memory models with programmable wait states, fetch and data-access logs.
module tb_multi_cycle_cpu;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b010001,
                         OP_OR = 6'b010010, OP_ADDIU = 6'b000010, OP_ORI = 6'b010000,
                         OP_SW = 6'b100110, OP_LW = 6'b100111, OP_BEQ = 6'b110000,
                         OP_BNE = 6'b110001, OP_J = 6'b111000, OP_HALT = 6'b111111;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [31:0] NOP_W  = 32'h0C00_0000;

  logic        CLK = 1'b0, Reset = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, currentAddress;
  logic [2:0]  state;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  int iWait = 0, dWait = 0, iCnt = 0, dCnt = 0, cyc = 0;
  logic dAckForce = 1'b0;
  int nVec = 0, nErr = 0;

  logic [31:0] fetchA[$];
  int          fetchC[$];
  int          dLenQ[$];
  logic [31:0] dAddrQ[$], dDataQ[$];
  logic        dWeQ[$];
  int          dLen = 0, dUnstable = 0;
  logic [31:0] dA0, dD0;

  multi_cycle_cpu dut (
    .CLK(CLK), .Reset(Reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .currentAddress(currentAddress), .state(state), .halted(halted)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // memory models: ack after iWait/dWait extra cycles of a held request
  assign imem_ack   = imem_req && (iCnt >= iWait);
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ack   = (dmem_req && (dCnt >= dWait)) || dAckForce;
  assign dmem_rdata = dmem[dmem_addr[5:2]];
  always @(posedge CLK) begin
    iCnt <= (imem_req && !imem_ack) ? iCnt + 1 : 0;
    dCnt <= (dmem_req && !dmem_ack) ? dCnt + 1 : 0;
  end

  initial forever begin
    @(posedge CLK);
    if (Reset && imem_req && imem_ack) begin
      fetchA.push_back(imem_addr);
      fetchC.push_back(cyc);
    end
  end

  initial forever begin
    @(posedge CLK);
    if (dmem_req) begin
      if (dLen == 0) begin
        dA0 = dmem_addr;
        dD0 = dmem_wdata;
      end else if (dmem_addr != dA0 || dmem_wdata != dD0) begin
        dUnstable++;
      end
      dLen++;
      if (dmem_ack) begin
        dLenQ.push_back(dLen);
        dAddrQ.push_back(dmem_addr);
        dWeQ.push_back(dmem_we);
        dDataQ.push_back(dmem_wdata);
        if (dmem_we) dmem[dmem_addr[5:2]] = dmem_wdata;
        dLen = 0;
      end
    end else begin
      dLen = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rEnc(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction
  function automatic logic [31:0] iEnc(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] jEnc(input logic [25:0] target);
    return {OP_J, target};
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 64; i++) imem[i] = HALT_W;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
  endtask

  task automatic doReset();
    Reset = 1'b0;
    dAckForce = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    fetchA.delete(); fetchC.delete();
    dLenQ.delete(); dAddrQ.delete(); dWeQ.delete(); dDataQ.delete();
    dUnstable = 0;
    Reset = 1'b1;
  endtask

  task automatic runToHalt(input int maxCyc, output int n);
    n = 0;
    while (n < maxCyc) begin
      @(posedge CLK); #1;
      n++;
      if (halted) break;
    end
  endtask

  initial begin
    int n;
    clearMem();

    // reset state, and first fetch right after Reset rises
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", state, 3'b000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc", currentAddress, 32'h0);
    chk("rst_ireq", imem_req, 1'b0);
    chk("rst_dreq", dmem_req, 1'b0);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    chk("first_ireq", imem_req, 1'b1);
    chk("first_iaddr", imem_addr, 32'h0);

    // zero-wait ALU program, 14 cycles to halt
    iWait = 0; dWait = 0;
    clearMem();
    imem[0] = iEnc(OP_ADDIU, 0, 1, 16'd5);
    imem[1] = iEnc(OP_ADDIU, 0, 2, 16'hFFFD);
    imem[2] = rEnc(OP_ADD, 1, 2, 3);
    imem[3] = HALT_W;
    doReset();
    runToHalt(100, n);
    chk("alu_cycles", n, 14);
    chk("alu_halted", halted, 1'b1);
    chk("alu_r3", dut.regFile[3], 32'd2);
    chk("alu_r2", dut.regFile[2], 32'hFFFF_FFFD);
    chk("alu_pc", currentAddress, 32'd12);
    chk("alu_state", state, 3'b101);
    n = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (imem_req || dmem_req || !halted) n++;
    end
    chk("halt_hold", n, 0);
    chk("halt_pc_hold", currentAddress, 32'd12);

    // store/load with 3 data wait cycles, r0 write discard, remaining ALU ops
    dWait = 3;
    clearMem();
    imem[0]  = iEnc(OP_ADDIU, 0, 1, 16'd5);
    imem[1]  = iEnc(OP_SW, 0, 1, 16'd8);
    imem[2]  = iEnc(OP_LW, 0, 4, 16'd8);
    imem[3]  = iEnc(OP_ADDIU, 0, 0, 16'd7);
    imem[4]  = rEnc(OP_ADD, 0, 0, 5);
    imem[5]  = rEnc(OP_SUB, 0, 1, 6);
    imem[6]  = iEnc(OP_ORI, 0, 7, 16'h8001);
    imem[7]  = rEnc(OP_AND, 7, 1, 8);
    imem[8]  = rEnc(OP_OR, 7, 1, 9);
    imem[9]  = iEnc(OP_ADDIU, 6, 10, 16'd5);
    imem[10] = HALT_W;
    doReset();
    runToHalt(300, n);
    chk("mem_halted", halted, 1'b1);
    chk("mem_accesses", dLenQ.size(), 2);
    chk("sw_len", dLenQ[0], 4);
    chk("sw_addr", dAddrQ[0], 32'd8);
    chk("sw_we", dWeQ[0], 1'b1);
    chk("sw_data", dDataQ[0], 32'd5);
    chk("lw_len", dLenQ[1], 4);
    chk("lw_addr", dAddrQ[1], 32'd8);
    chk("lw_we", dWeQ[1], 1'b0);
    chk("dmem_stable", dUnstable, 0);
    chk("lw_r4", dut.regFile[4], 32'd5);
    chk("r0_zero", dut.regFile[0], 32'd0);
    chk("r0_read_r5", dut.regFile[5], 32'd0);
    chk("sub_r6", dut.regFile[6], 32'hFFFF_FFFB);
    chk("ori_zext_r7", dut.regFile[7], 32'h0000_8001);
    chk("and_r8", dut.regFile[8], 32'h1);
    chk("or_r9", dut.regFile[9], 32'h8005);
    chk("wrap_r10", dut.regFile[10], 32'h0);

    // branches at 0x20 with one instruction wait cycle
    iWait = 1; dWait = 0;
    clearMem();
    imem[0] = iEnc(OP_ADDIU, 0, 1, 16'd9);
    imem[1] = jEnc(26'd8);
    imem[8] = iEnc(OP_BEQ, 1, 1, 16'hFFFF);
    imem[9] = HALT_W;
    doReset();
    n = 0;
    while (n < 60 && fetchA.size() < 3) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("br_reach", fetchA.size(), 3);
    imem[8] = iEnc(OP_BNE, 1, 1, 16'hFFFF);
    runToHalt(100, n);
    chk("br_halted", halted, 1'b1);
    chk("br_fetches", fetchA.size(), 5);
    chk("j_to_20", fetchA[2], 32'h20);
    chk("beq_taken", fetchA[3], 32'h20);
    chk("bne_fall", fetchA[4], 32'h24);
    chk("addiu_lat_w1", fetchC[1] - fetchC[0], 5);
    chk("j_lat_w1", fetchC[2] - fetchC[1], 3);
    chk("beq_lat_w1", fetchC[3] - fetchC[2], 4);
    chk("bne_lat_w1", fetchC[4] - fetchC[3], 4);
    chk("br_pc", currentAddress, 32'h24);

    // jump region boundary and PC wrap: j 0x3FFFFFF / NOP pairs walk all 16 regions
    iWait = 0;
    clearMem();
    imem[0]  = jEnc(26'h3FF_FFFF);
    imem[63] = NOP_W;
    doReset();
    n = 0;
    while (n < 300 && fetchA.size() < 34) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("jmp_fetches", fetchA.size(), 34);
    chk("jmp_first", fetchA[1], 32'h0FFF_FFFC);
    chk("nop_next", fetchA[2], 32'h1000_0000);
    chk("jmp_1000", fetchA[3], 32'h1FFF_FFFC);
    chk("jmp_top", fetchA[31], 32'hFFFF_FFFC);
    chk("pc_wrap", fetchA[32], 32'h0);
    chk("nop_lat", fetchC[2] - fetchC[1], 2);
    chk("j_lat", fetchC[3] - fetchC[2], 2);

    // reset arriving during a pending load with ack forced high
    dWait = 10;
    clearMem();
    imem[0] = iEnc(OP_LW, 0, 12, 16'd0);
    imem[1] = HALT_W;
    dmem[0] = 32'h1234;
    doReset();
    n = 0;
    while (n < 50 && state != 3'b011) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("reach_mem", state, 3'b011);
    @(negedge CLK);
    Reset = 1'b0;
    dAckForce = 1'b1;
    #1;
    chk("rstmem_dreq_now", dmem_req, 1'b0);
    @(posedge CLK); #1;
    chk("rstmem_state", state, 3'b000);
    chk("rstmem_pc", currentAddress, 32'h0);
    chk("rstmem_dreq", dmem_req, 1'b0);
    chk("rstmem_r12", dut.regFile[12], 32'h0);
    chk("rstmem_mdr", dut.mdr, 32'h0);
    @(negedge CLK);
    dAckForce = 1'b0;
    Reset = 1'b1;
    runToHalt(100, n);
    chk("relaunch_halted", halted, 1'b1);
    chk("relaunch_r12", dut.regFile[12], 32'h1234);
    chk("relaunch_lw_len", dLenQ[0], 11);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
